// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE-array command controller: FSM state, request bit indices, status word layout.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_XFER = 3'd2,
        ST_POP  = 3'd3,
        ST_ACK  = 3'd4
    } state_e;

    localparam int unsigned REQ_XID    = 0;
    localparam int unsigned REQ_YID    = 1;
    localparam int unsigned REQ_LN     = 2;
    localparam int unsigned REQ_PE     = 3;
    localparam int unsigned REQ_FILTER = 4;
    localparam int unsigned REQ_IFMAP  = 5;
    localparam int unsigned REQ_IPSUM  = 6;
    localparam int unsigned REQ_POP    = 7;

    // acc_ctrl status word, MSB first
    typedef struct packed {
        logic [11:0] rsvd;
        logic        ifmap_ready;
        logic        filter_ready;
        logic        ipsum_ready;
        logic        opsum_valid;
        logic [7:0]  count;
        logic        empty;
        logic        full;
        logic        underflow;
        logic        timeout;
        logic        ack;
        state_e      state;
    } acc_ctrl_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/pe_array_cmd_ctrl_if.sv
// CPU command/status bus plus GLB transfer and opsum streams between the controller and its environment.
interface pe_array_cmd_ctrl_if #(
    parameter int unsigned XID_W  = 5,
    parameter int unsigned YID_W  = 3,
    parameter int unsigned DATA_W = 32
);
    logic [7:0]        req;
    logic [31:0]       cpu_ctrl;
    logic [DATA_W-1:0] cpu_data;
    logic              ack;
    logic [31:0]       acc_ctrl;
    logic [DATA_W-1:0] acc_data;

    logic [XID_W-1:0]  tag_X;
    logic [YID_W-1:0]  tag_Y;
    logic              GLB_filter_valid, GLB_ifmap_valid, GLB_ipsum_valid;
    logic              GLB_filter_ready, GLB_ifmap_ready, GLB_ipsum_ready;
    logic [DATA_W-1:0] GLB_data_in;
    logic              GLB_opsum_valid, GLB_opsum_ready;
    logic [DATA_W-1:0] GLB_data_out;

    modport master (
        output req, cpu_ctrl, cpu_data,
        output GLB_filter_ready, GLB_ifmap_ready, GLB_ipsum_ready, GLB_opsum_valid, GLB_data_out,
        input  ack, acc_ctrl, acc_data, tag_X, tag_Y,
        input  GLB_filter_valid, GLB_ifmap_valid, GLB_ipsum_valid, GLB_data_in, GLB_opsum_ready
    );

    modport slave (
        input  req, cpu_ctrl, cpu_data,
        input  GLB_filter_ready, GLB_ifmap_ready, GLB_ipsum_ready, GLB_opsum_valid, GLB_data_out,
        output ack, acc_ctrl, acc_data, tag_X, tag_Y,
        output GLB_filter_valid, GLB_ifmap_valid, GLB_ipsum_valid, GLB_data_in, GLB_opsum_ready
    );
endinterface

// File: rtl/opsum_fifo.sv
// Synchronous opsum FIFO; exposes current and next occupancy so the owner can register full/ready.
module opsum_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count,
    output logic [$clog2(DEPTH):0]  count_d
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    assign head    = mem[rd_ptr];
    assign count_d = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pe_array_cmd_ctrl.sv
// CPU-to-PE-array command controller: config scans, GLB transfers, opsum FIFO pops, req/ack handshake.
// Optional transfer watchdog enabled by defining PE_CTRL_TIMEOUT_EN.
module pe_array_cmd_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned XID_W       = 5,
    parameter int unsigned YID_W       = 3,
    parameter int unsigned LN_W        = 5,
    parameter int unsigned PE_NUM      = 48,
    parameter int unsigned PE_CFG_W    = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned OPSUM_DEPTH = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    pe_array_cmd_ctrl_if.slave  bus,
    output logic                set_XID,
    output logic                set_YID,
    output logic                set_LN,
    output logic [XID_W-1:0]    ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in,
    output logic [YID_W-1:0]    ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in,
    output logic [LN_W-1:0]     LN_config_in,
    output logic [PE_NUM-1:0]   PE_en,
    output logic [PE_CFG_W-1:0] PE_config
);
    localparam int unsigned CNT_W = $clog2(OPSUM_DEPTH) + 1;

    state_e            state, state_d;
    logic [2:0]        valid_q, valid_d;          // {ipsum, ifmap, filter}
    logic [XID_W-1:0]  tag_x_q, tag_x_d;
    logic [YID_W-1:0]  tag_y_q, tag_y_d;
    logic [DATA_W-1:0] data_q, data_d, acc_data_q, acc_data_d, head;
    logic              ack_q, ack_d, tmo_q, tmo_d, unf_q, unf_d, opsum_rdy_q;
    logic [31:0]       acc_ctrl_q;
    acc_ctrl_t         acc_ctrl_d;
    logic              set_xid_d, set_yid_d, set_ln_d;
    logic [XID_W-1:0]  xid_d [4];
    logic [YID_W-1:0]  yid_d [4];
    logic [LN_W-1:0]   ln_d;
    logic [PE_NUM-1:0] pe_en_d;
    logic [PE_CFG_W-1:0] pe_cfg_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              push, pop, accept, timeout_hit, cmd_ok, go, unused_ok;

    assign cmd_ok    = is_onehot8(bus.req);
    assign go        = bus.cpu_ctrl[XID_W+YID_W];
    assign accept    = |(valid_q & {bus.GLB_ipsum_ready, bus.GLB_ifmap_ready, bus.GLB_filter_ready});
    assign push      = bus.GLB_opsum_valid && opsum_rdy_q;
    assign unused_ok = ^{bus.cpu_ctrl, TIMEOUT_CYC[0]};

`ifdef PE_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (!rst)                 tmo_cnt <= '0;
        else if (state == ST_XFER) tmo_cnt <= tmo_cnt + TMO_W'(1);
        else                      tmo_cnt <= '0;
    end
    assign timeout_hit = (state == ST_XFER) && (|valid_q) && !accept &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    opsum_fifo #(.DATA_W(DATA_W), .DEPTH(OPSUM_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus.GLB_data_out),
        .head(head), .count(cnt), .count_d(cnt_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (cmd_ok) begin
                if (|bus.req[REQ_PE:REQ_XID])          state_d = ST_CFG;
                else if (|bus.req[REQ_IPSUM:REQ_FILTER]) state_d = ST_XFER;
                else                                    state_d = ST_POP;
            end
            ST_CFG:  state_d = ST_ACK;
            ST_XFER: if (!(|valid_q) || accept || timeout_hit) state_d = ST_ACK;
            ST_POP:  state_d = ST_ACK;
            ST_ACK:  if (bus.req == 8'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output; config fields live only for the CFG cycle
    always_comb begin
        set_xid_d = 1'b0; set_yid_d = 1'b0; set_ln_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xid_d[i] = '0;
            yid_d[i] = '0;
        end
        ln_d = '0; pe_en_d = '0; pe_cfg_d = '0;
        valid_d = valid_q; tag_x_d = tag_x_q; tag_y_d = tag_y_q; data_d = data_q;
        tmo_d = tmo_q; unf_d = unf_q; acc_data_d = acc_data_q; pop = 1'b0;
        ack_d = (state_d == ST_ACK);

        if (state == ST_IDLE && state_d != ST_IDLE) begin
            tmo_d = 1'b0;
            unf_d = 1'b0;
            if (bus.req[REQ_XID]) begin
                set_xid_d = bus.cpu_ctrl[4*XID_W];
                for (int i = 0; i < 4; i++) xid_d[i] = bus.cpu_ctrl[i*XID_W +: XID_W];
            end
            if (bus.req[REQ_YID]) begin
                set_yid_d = bus.cpu_ctrl[4*YID_W];
                for (int i = 0; i < 4; i++) yid_d[i] = bus.cpu_ctrl[i*YID_W +: YID_W];
            end
            if (bus.req[REQ_LN]) begin
                set_ln_d = bus.cpu_ctrl[LN_W];
                ln_d     = bus.cpu_ctrl[LN_W-1:0];
            end
            if (bus.req[REQ_PE]) begin
                pe_en_d  = {PE_NUM{bus.cpu_ctrl[PE_CFG_W]}};
                pe_cfg_d = bus.cpu_ctrl[PE_CFG_W-1:0];
            end
            if (state_d == ST_XFER) begin
                valid_d = {bus.req[REQ_IPSUM], bus.req[REQ_IFMAP], bus.req[REQ_FILTER]} & {3{go}};
                tag_x_d = bus.cpu_ctrl[XID_W-1:0];
                tag_y_d = bus.cpu_ctrl[XID_W +: YID_W];
                data_d  = bus.cpu_data;
            end
        end

        if (state == ST_XFER && state_d == ST_ACK) begin
            valid_d = '0; tag_x_d = '0; tag_y_d = '0; data_d = '0;
            tmo_d   = timeout_hit;
        end

        if (state == ST_POP) begin
            if (cnt != '0) begin
                pop        = 1'b1;
                acc_data_d = head;
            end else begin
                unf_d = 1'b1;
            end
        end

        acc_ctrl_d              = '0;
        acc_ctrl_d.state        = state_d;
        acc_ctrl_d.ack          = ack_d;
        acc_ctrl_d.timeout      = tmo_d;
        acc_ctrl_d.underflow    = unf_d;
        acc_ctrl_d.full         = (cnt_d == CNT_W'(OPSUM_DEPTH));
        acc_ctrl_d.empty        = (cnt_d == '0);
        acc_ctrl_d.count        = 8'(cnt_d);
        acc_ctrl_d.ifmap_ready  = bus.GLB_ifmap_ready;
        acc_ctrl_d.filter_ready = bus.GLB_filter_ready;
        acc_ctrl_d.ipsum_ready  = bus.GLB_ipsum_ready;
        acc_ctrl_d.opsum_valid  = bus.GLB_opsum_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            set_XID <= 1'b0; set_YID <= 1'b0; set_LN <= 1'b0;
            ifmap_XID_scan_in <= '0; filter_XID_scan_in <= '0; ipsum_XID_scan_in <= '0; opsum_XID_scan_in <= '0;
            ifmap_YID_scan_in <= '0; filter_YID_scan_in <= '0; ipsum_YID_scan_in <= '0; opsum_YID_scan_in <= '0;
            LN_config_in <= '0; PE_en <= '0; PE_config <= '0;
            valid_q <= '0; tag_x_q <= '0; tag_y_q <= '0; data_q <= '0;
            ack_q <= 1'b0; tmo_q <= 1'b0; unf_q <= 1'b0; acc_data_q <= '0;
            acc_ctrl_q <= '0; opsum_rdy_q <= 1'b1;
        end else begin
            set_XID <= set_xid_d; set_YID <= set_yid_d; set_LN <= set_ln_d;
            ifmap_XID_scan_in <= xid_d[0]; filter_XID_scan_in <= xid_d[1];
            ipsum_XID_scan_in <= xid_d[2]; opsum_XID_scan_in  <= xid_d[3];
            ifmap_YID_scan_in <= yid_d[0]; filter_YID_scan_in <= yid_d[1];
            ipsum_YID_scan_in <= yid_d[2]; opsum_YID_scan_in  <= yid_d[3];
            LN_config_in <= ln_d; PE_en <= pe_en_d; PE_config <= pe_cfg_d;
            valid_q <= valid_d; tag_x_q <= tag_x_d; tag_y_q <= tag_y_d; data_q <= data_d;
            ack_q <= ack_d; tmo_q <= tmo_d; unf_q <= unf_d; acc_data_q <= acc_data_d;
            acc_ctrl_q  <= acc_ctrl_d;
            opsum_rdy_q <= (cnt_d != CNT_W'(OPSUM_DEPTH));
        end
    end

    assign bus.ack              = ack_q;
    assign bus.acc_ctrl         = acc_ctrl_q;
    assign bus.acc_data         = acc_data_q;
    assign bus.tag_X            = tag_x_q;
    assign bus.tag_Y            = tag_y_q;
    assign bus.GLB_filter_valid = valid_q[0];
    assign bus.GLB_ifmap_valid  = valid_q[1];
    assign bus.GLB_ipsum_valid  = valid_q[2];
    assign bus.GLB_data_in      = data_q;
    assign bus.GLB_opsum_ready  = opsum_rdy_q;
endmodule

// File: tb/tb_pe_array_cmd_ctrl.sv
// Directed self-checking bench for pe_array_cmd_ctrl (default build; watchdog scenario under PE_CTRL_TIMEOUT_EN).
module tb_pe_array_cmd_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic        set_XID, set_YID, set_LN;
    logic [4:0]  ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in;
    logic [2:0]  ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in;
    logic [4:0]  LN_config_in;
    logic [47:0] PE_en;
    logic [9:0]  PE_config;

    pe_array_cmd_ctrl_if #(.XID_W(5), .YID_W(3), .DATA_W(32)) bus ();

    pe_array_cmd_ctrl #(
        .XID_W(5), .YID_W(3), .LN_W(5), .PE_NUM(48), .PE_CFG_W(10),
        .DATA_W(32), .OPSUM_DEPTH(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .set_XID(set_XID), .set_YID(set_YID), .set_LN(set_LN),
        .ifmap_XID_scan_in(ifmap_XID_scan_in), .filter_XID_scan_in(filter_XID_scan_in),
        .ipsum_XID_scan_in(ipsum_XID_scan_in), .opsum_XID_scan_in(opsum_XID_scan_in),
        .ifmap_YID_scan_in(ifmap_YID_scan_in), .filter_YID_scan_in(filter_YID_scan_in),
        .ipsum_YID_scan_in(ipsum_YID_scan_in), .opsum_YID_scan_in(opsum_YID_scan_in),
        .LN_config_in(LN_config_in), .PE_en(PE_en), .PE_config(PE_config)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_req();
        bus.req = 8'd0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = 8'd0; bus.cpu_ctrl = 32'd0; bus.cpu_data = 32'd0;
        bus.GLB_filter_ready = 1'b0; bus.GLB_ifmap_ready = 1'b0; bus.GLB_ipsum_ready = 1'b0;
        bus.GLB_opsum_valid = 1'b0; bus.GLB_data_out = 32'd0;
        step(3);
        checks++; if (bus.acc_ctrl !== 32'd0) begin errors++; $display("FAIL reset_acc_ctrl got=%h exp=0", bus.acc_ctrl); end
        checks++; if (bus.ack !== 1'b0 || bus.acc_data !== 32'd0) begin errors++; $display("FAIL reset_ack_data ack=%b data=%h exp 0/0", bus.ack, bus.acc_data); end
        checks++; if (bus.GLB_opsum_ready !== 1'b1) begin errors++; $display("FAIL reset_opsum_ready got=%b exp=1", bus.GLB_opsum_ready); end
        checks++; if ({bus.GLB_filter_valid, bus.GLB_ifmap_valid, bus.GLB_ipsum_valid, set_XID, set_YID, set_LN} !== 6'd0 || PE_en !== 48'd0)
            begin errors++; $display("FAIL reset_strobes got=%b pe_en=%h exp all 0", {bus.GLB_filter_valid, bus.GLB_ifmap_valid, bus.GLB_ipsum_valid, set_XID, set_YID, set_LN}, PE_en); end
        rst = 1'b1;
        step(1);
        checks++; if (bus.acc_ctrl !== 32'h0000_0080) begin errors++; $display("FAIL idle_status got=%h exp=00000080", bus.acc_ctrl); end
    endtask

    task automatic test_cfg_xid();
        bus.req = 8'h01; bus.cpu_ctrl = 32'h0010_8421;
        step(1);
        checks++; if (set_XID !== 1'b1 || ifmap_XID_scan_in !== 5'd1 || filter_XID_scan_in !== 5'd1 || ipsum_XID_scan_in !== 5'd1 || opsum_XID_scan_in !== 5'd1)
            begin errors++; $display("FAIL xid_cfg set=%b ids=%0d,%0d,%0d,%0d exp 1 and 1,1,1,1", set_XID, ifmap_XID_scan_in, filter_XID_scan_in, ipsum_XID_scan_in, opsum_XID_scan_in); end
        checks++; if (bus.ack !== 1'b0 || bus.acc_ctrl[2:0] !== 3'd1) begin errors++; $display("FAIL xid_cfg_state ack=%b st=%0d exp 0/1", bus.ack, bus.acc_ctrl[2:0]); end
        step(1);
        checks++; if (set_XID !== 1'b0 || ifmap_XID_scan_in !== 5'd0 || bus.ack !== 1'b1) begin errors++; $display("FAIL xid_one_cycle set=%b id=%0d ack=%b exp 0/0/1", set_XID, ifmap_XID_scan_in, bus.ack); end
        step(3);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL xid_ack_hold got=%b exp=1", bus.ack); end
        bus.req = 8'd0;
        step(1);
        checks++; if (bus.ack !== 1'b0 || bus.acc_ctrl[2:0] !== 3'd0) begin errors++; $display("FAIL xid_ack_drop ack=%b st=%0d exp 0/0", bus.ack, bus.acc_ctrl[2:0]); end
    endtask

    task automatic test_cfg_yid_ln_pe();
        bus.req = 8'h02; bus.cpu_ctrl = 32'h0000_18D1;
        step(1);
        checks++; if (set_YID !== 1'b1 || ifmap_YID_scan_in !== 3'd1 || filter_YID_scan_in !== 3'd2 || ipsum_YID_scan_in !== 3'd3 || opsum_YID_scan_in !== 3'd4 || set_XID !== 1'b0)
            begin errors++; $display("FAIL yid_cfg set=%b ids=%0d,%0d,%0d,%0d setx=%b exp 1 1,2,3,4 0", set_YID, ifmap_YID_scan_in, filter_YID_scan_in, ipsum_YID_scan_in, opsum_YID_scan_in, set_XID); end
        release_req();
        bus.req = 8'h04; bus.cpu_ctrl = 32'h0000_0033;
        step(1);
        checks++; if (set_LN !== 1'b1 || LN_config_in !== 5'h13) begin errors++; $display("FAIL ln_cfg set=%b cfg=%h exp 1/13", set_LN, LN_config_in); end
        release_req();
        bus.req = 8'h08; bus.cpu_ctrl = 32'h0000_06A5;
        step(1);
        checks++; if (PE_en !== 48'hFFFF_FFFF_FFFF || PE_config !== 10'h2A5) begin errors++; $display("FAIL pe_cfg en=%h cfg=%h exp ffffffffffff/2a5", PE_en, PE_config); end
        step(1);
        checks++; if (PE_en !== 48'd0 || PE_config !== 10'd0) begin errors++; $display("FAIL pe_cfg_clear en=%h cfg=%h exp 0/0", PE_en, PE_config); end
        release_req();
    endtask

    task automatic test_xfer_filter();
        bus.req = 8'h10; bus.cpu_ctrl = 32'h0000_01D5; bus.cpu_data = 32'hDEAD_BEEF;
        bus.GLB_filter_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            checks++;
            if (bus.GLB_filter_valid !== 1'b1 || bus.GLB_data_in !== 32'hDEAD_BEEF || bus.ack !== 1'b0 || bus.GLB_ifmap_valid !== 1'b0)
                begin errors++; $display("FAIL filter_hold cyc=%0d valid=%b data=%h ack=%b exp 1/deadbeef/0", i, bus.GLB_filter_valid, bus.GLB_data_in, bus.ack); end
            if (i == 0) begin
                checks++; if (bus.tag_X !== 5'h15 || bus.tag_Y !== 3'h6) begin errors++; $display("FAIL filter_tags x=%h y=%h exp 15/6", bus.tag_X, bus.tag_Y); end
            end
            if (i == 5) bus.GLB_filter_ready = 1'b1;
        end
        step(1);
        checks++; if (bus.GLB_filter_valid !== 1'b0 || bus.ack !== 1'b1) begin errors++; $display("FAIL filter_accept valid=%b ack=%b exp 0/1", bus.GLB_filter_valid, bus.ack); end
        bus.GLB_filter_ready = 1'b0;
        release_req();
    endtask

    task automatic test_xfer_req_drop();
        bus.req = 8'h20; bus.cpu_ctrl = 32'h0000_0100; bus.cpu_data = 32'h1234_5678;
        bus.GLB_ifmap_ready = 1'b0;
        step(1);
        bus.req = 8'd0;
        step(1);
        checks++; if (bus.GLB_ifmap_valid !== 1'b1 || bus.GLB_data_in !== 32'h1234_5678) begin errors++; $display("FAIL ifmap_no_abort valid=%b data=%h exp 1/12345678", bus.GLB_ifmap_valid, bus.GLB_data_in); end
        bus.GLB_ifmap_ready = 1'b1;
        step(1);
        checks++; if (bus.GLB_ifmap_valid !== 1'b0 || bus.ack !== 1'b1) begin errors++; $display("FAIL ifmap_done valid=%b ack=%b exp 0/1", bus.GLB_ifmap_valid, bus.ack); end
        bus.GLB_ifmap_ready = 1'b0;
        step(1);
        checks++; if (bus.ack !== 1'b0 || bus.acc_ctrl[2:0] !== 3'd0) begin errors++; $display("FAIL ifmap_idle ack=%b st=%0d exp 0/0", bus.ack, bus.acc_ctrl[2:0]); end
        // go bit clear: one XFER cycle, no valid, then ack
        bus.req = 8'h40; bus.cpu_ctrl = 32'h0000_0000;
        step(1);
        checks++; if (bus.GLB_ipsum_valid !== 1'b0 || bus.acc_ctrl[2:0] !== 3'd2) begin errors++; $display("FAIL nogo_xfer valid=%b st=%0d exp 0/2", bus.GLB_ipsum_valid, bus.acc_ctrl[2:0]); end
        step(1);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL nogo_ack got=%b exp=1", bus.ack); end
        release_req();
    endtask

    task automatic test_opsum_fifo();
        logic [31:0] exp_q [4];
        exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC; exp_q[3] = 32'hD;
        bus.GLB_opsum_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.GLB_data_out = exp_q[i];
            step(1);
        end
        bus.GLB_data_out = 32'hE;
        checks++; if (bus.GLB_opsum_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got=%b exp=0", bus.GLB_opsum_ready); end
        checks++; if (bus.acc_ctrl[15:0] !== 16'h0440) begin errors++; $display("FAIL fifo_full_status got=%h exp=0440", bus.acc_ctrl[15:0]); end
        step(2);
        bus.GLB_opsum_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req = 8'h80;
            step(2);
            checks++; if (bus.acc_data !== exp_q[i] || bus.ack !== 1'b1) begin errors++; $display("FAIL pop_%0d data=%h ack=%b exp %h/1", i, bus.acc_data, bus.ack, exp_q[i]); end
            bus.req = 8'd0;
            step(1);
        end
        checks++; if (bus.acc_ctrl[7] !== 1'b1 || bus.GLB_opsum_ready !== 1'b1) begin errors++; $display("FAIL fifo_empty empty=%b ready=%b exp 1/1", bus.acc_ctrl[7], bus.GLB_opsum_ready); end
        bus.req = 8'h80;
        step(2);
        checks++; if (bus.acc_ctrl[5] !== 1'b1 || bus.acc_data !== 32'hD) begin errors++; $display("FAIL underflow flag=%b data=%h exp 1/d", bus.acc_ctrl[5], bus.acc_data); end
        release_req();
    endtask

    task automatic test_push_pop_same_cycle();
        bus.GLB_opsum_valid = 1'b1; bus.GLB_data_out = 32'h11;
        step(1);
        bus.GLB_opsum_valid = 1'b0; bus.req = 8'h80;
        step(1);
        bus.GLB_opsum_valid = 1'b1; bus.GLB_data_out = 32'h22;
        step(1);
        bus.GLB_opsum_valid = 1'b0;
        checks++; if (bus.acc_data !== 32'h11 || bus.acc_ctrl[15:8] !== 8'd1 || bus.acc_ctrl[5] !== 1'b0)
            begin errors++; $display("FAIL push_pop data=%h count=%0d unf=%b exp 11/1/0", bus.acc_data, bus.acc_ctrl[15:8], bus.acc_ctrl[5]); end
        release_req();
        bus.req = 8'h80;
        step(2);
        checks++; if (bus.acc_data !== 32'h22 || bus.acc_ctrl[15:8] !== 8'd0) begin errors++; $display("FAIL push_pop_second data=%h count=%0d exp 22/0", bus.acc_data, bus.acc_ctrl[15:8]); end
        release_req();
    endtask

    task automatic test_multi_hot();
        bus.req = 8'h03; bus.cpu_ctrl = 32'h0010_8421;
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++; if (bus.ack !== 1'b0 || bus.acc_ctrl[2:0] !== 3'd0 || set_XID !== 1'b0)
                begin errors++; $display("FAIL multi_hot cyc=%0d ack=%b st=%0d set=%b exp 0/0/0", i, bus.ack, bus.acc_ctrl[2:0], set_XID); end
        end
        bus.req = 8'd0;
        step(1);
    endtask

    task automatic test_reset_mid_xfer();
        bus.req = 8'h10; bus.cpu_ctrl = 32'h0000_0100; bus.GLB_filter_ready = 1'b0;
        step(2);
        checks++; if (bus.GLB_filter_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", bus.GLB_filter_valid); end
        rst = 1'b0;
        step(1);
        checks++; if (bus.GLB_filter_valid !== 1'b0 || bus.acc_ctrl !== 32'd0 || bus.ack !== 1'b0)
            begin errors++; $display("FAIL rst_mid_xfer valid=%b status=%h ack=%b exp 0/0/0", bus.GLB_filter_valid, bus.acc_ctrl, bus.ack); end
        bus.req = 8'd0; rst = 1'b1;
        step(2);
    endtask

`ifdef PE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        bus.req = 8'h40; bus.cpu_ctrl = 32'h0000_0100; bus.GLB_ipsum_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.GLB_ipsum_valid !== 1'b1) break;
            n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL timeout_len got=%0d exp=8", n); end
        checks++; if (bus.acc_ctrl[4] !== 1'b1 || bus.ack !== 1'b1) begin errors++; $display("FAIL timeout_flag flag=%b ack=%b exp 1/1", bus.acc_ctrl[4], bus.ack); end
        release_req();
    endtask
`endif

    initial begin
        test_reset();
        test_cfg_xid();
        test_cfg_yid_ln_pe();
        test_xfer_filter();
        test_xfer_req_drop();
        test_opsum_fifo();
        test_push_pop_same_cycle();
        test_multi_hot();
        test_reset_mid_xfer();
`ifdef PE_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
